mem_arbiter: RTL and testbench
==============================

# mem_arbiter

Two-requester memory arbiter between the CPU request unit and the single shared memory bus. It accepts instruction-fetch reads and data reads/writes and grants one bus transaction at a time. Data has priority, with a starvation guard that forces an instruction grant after a bounded run of data grants. Each requester gets read data and a one-cycle ready pulse per completed transaction.

## Interface
- ADDR_W, 32, address width
- DATA_W, 32, data width
- MAX_D_STREAK, 4, consecutive data grants allowed while a fetch waits (≥1)

- CLK  in  1  clock, rising edge
- nRST  in  1  reset, asynchronous, active-low
- i_ren  in  1  instruction fetch request
- i_addr  in  ADDR_W  fetch address
- i_rdata  out  DATA_W  fetched word, registered
- i_ready  out  1  one-cycle completion pulse, fetch
- d_ren  in  1  data read request
- d_wen  in  1  data write request
- d_addr  in  ADDR_W  data address
- d_wdata  in  DATA_W  store data
- d_rdata  out  DATA_W  load data, registered
- d_ready  out  1  one-cycle completion pulse, data
- bus_ren  out  1  bus read strobe
- bus_wen  out  1  bus write strobe
- bus_addr  out  ADDR_W  bus address
- bus_wdata  out  DATA_W  bus store data
- bus_rdata  in  DATA_W  bus read data, valid when bus_busy=0
- bus_busy  in  1  bus still working on the current strobe

## Operation
- States: IDLE, I_BUS, D_BUS.
- Effective requests in a cycle: i_req = i_ren & ~i_ready; d_req = (d_ren|d_wen) & ~d_ready. A requester in its ready cycle is ignored, because it is still holding its request that cycle.
- IDLE, decision at the clock edge:
  - only i_req → I_BUS.
  - only d_req → D_BUS.
  - both, streak < MAX_D_STREAK → D_BUS.
  - both, streak == MAX_D_STREAK → I_BUS.
- On a grant, address, wdata and op are latched; bus outputs come only from latched registers. Requester inputs may change after the grant without effect.
- If d_ren and d_wen are both high, the request is a write (d_wen wins).
- I_BUS: bus_ren=1, bus_wen=0, bus_addr=latched i_addr.
- D_BUS: bus_ren or bus_wen per latched op, bus_addr=latched d_addr, bus_wdata=latched d_wdata.
- Completion: in I_BUS or D_BUS with bus_busy=0 at the edge:
  - capture bus_rdata into i_rdata or d_rdata (writes leave d_rdata unchanged);
  - pulse the matching ready for the next cycle;
  - return to IDLE.
- Streak counter, width clog2(MAX_D_STREAK+1):
  - +1 on a D grant made while i_req was high;
  - cleared on any I grant;
  - cleared on a D grant made with i_req low;
  - saturates at MAX_D_STREAK.
- rdata registers hold their value until the next completion of the same requester.

## Timing
- Reset (async, any state, including mid-transaction) sets:
  - state=IDLE, streak=0, i_ready=d_ready=0;
  - bus_ren=bus_wen=0, bus_addr=0, bus_wdata=0;
  - i_rdata=d_rdata=0.
- A transaction aborted by reset is not completed and produces no ready.
- Latency: request seen in IDLE at edge N puts the strobe on the bus in cycle N+1. If bus_busy=0 in cycle N+1, ready is high in cycle N+2 and the arbiter is back in IDLE.
- Minimum request-to-ready is 2 cycles; each busy cycle adds 1.
- Bus strobes are never asserted in IDLE, so there is at least one idle bus cycle between transactions.
- The ready cycle is also an IDLE decision cycle, so the other requester can be granted in that cycle.
- Strobes stay high and stable for the whole duration of bus_busy.

## Test plan
- Single fetch, i_addr=0x100, bus_busy=0, bus_rdata=0xDEADBEEF → bus_ren high 1 cycle with bus_addr=0x100; i_ready pulses 2 cycles after the request with i_rdata=0xDEADBEEF; d_ready stays 0.
- Data write, d_wen=1, d_addr=0x2000, d_wdata=0x12345678, bus_busy high 3 cycles → bus_wen held 4 cycles with stable addr/data; d_ready pulses once; d_rdata unchanged.
- Simultaneous i_ren and d_ren from IDLE → D granted first; after d_ready, I granted in the ready cycle; exactly one i_ready and one d_ready.
- i_ren held high while d_ren is re-requested continuously, MAX_D_STREAK=4 → grant order D,D,D,D,I,D…; streak returns to 0 after the I grant.
- Reset asserted during D_BUS with bus_busy=1 → bus_ren/bus_wen drop immediately (async); no d_ready; after release a pending i_ren is served normally.
- d_ren=d_wen=1 at d_addr=0x40 → bus_wen=1, bus_ren=0.

Source files
------------

// File: rtl/mem_arbiter.sv
// Two-requester memory arbiter: instruction fetch and data share one bus.
// Data normally wins, but a bounded run of data grants forces a waiting fetch through.
module mem_arbiter #(
    parameter int ADDR_W       = 32,
    parameter int DATA_W       = 32,
    parameter int MAX_D_STREAK = 4
) (
    input  logic              CLK,
    input  logic              nRST,
    input  logic              i_ren,
    input  logic [ADDR_W-1:0] i_addr,
    output logic [DATA_W-1:0] i_rdata,
    output logic              i_ready,
    input  logic              d_ren,
    input  logic              d_wen,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic [DATA_W-1:0] d_rdata,
    output logic              d_ready,
    output logic              bus_ren,
    output logic              bus_wen,
    output logic [ADDR_W-1:0] bus_addr,
    output logic [DATA_W-1:0] bus_wdata,
    input  logic [DATA_W-1:0] bus_rdata,
    input  logic              bus_busy
);

    localparam int SW = $clog2(MAX_D_STREAK + 1);
    localparam logic [SW-1:0] MAX_S = SW'(MAX_D_STREAK);

    typedef enum logic [1:0] {IDLE, I_BUS, D_BUS} state_e;

    state_e            state_q, state_d;
    logic [SW-1:0]     streak_q, streak_d;
    logic              iReady_q, iReady_d;
    logic              dReady_q, dReady_d;
    logic [DATA_W-1:0] iRdata_q, iRdata_d;
    logic [DATA_W-1:0] dRdata_q, dRdata_d;
    logic              busRen_q, busRen_d;
    logic              busWen_q, busWen_d;
    logic [ADDR_W-1:0] busAddr_q, busAddr_d;
    logic [DATA_W-1:0] busWdata_q, busWdata_d;

    logic iReq, dReq, grantI, grantD, done;

    // A requester is still holding its request during its ready cycle, so mask it there.
    assign iReq   = i_ren & ~iReady_q;
    assign dReq   = (d_ren | d_wen) & ~dReady_q;
    assign grantI = (state_q == IDLE) && (state_d == I_BUS);
    assign grantD = (state_q == IDLE) && (state_d == D_BUS);
    assign done   = (state_q != IDLE) && !bus_busy;

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (dReq && (!iReq || streak_q != MAX_S)) begin
                    state_d = D_BUS;
                end else if (iReq) begin
                    state_d = I_BUS;
                end
            end
            I_BUS, D_BUS: begin
                if (!bus_busy) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Bus outputs are driven only from values latched at grant time.
    always_comb begin
        busRen_d   = busRen_q;
        busWen_d   = busWen_q;
        busAddr_d  = busAddr_q;
        busWdata_d = busWdata_q;
        streak_d   = streak_q;
        iRdata_d   = iRdata_q;
        dRdata_d   = dRdata_q;
        iReady_d   = 1'b0;
        dReady_d   = 1'b0;
        if (grantI) begin
            busRen_d  = 1'b1;
            busWen_d  = 1'b0;
            busAddr_d = i_addr;
            streak_d  = '0;
        end else if (grantD) begin
            busRen_d   = ~d_wen;
            busWen_d   = d_wen;
            busAddr_d  = d_addr;
            busWdata_d = d_wdata;
            if (!iReq) begin
                streak_d = '0;
            end else if (streak_q != MAX_S) begin
                streak_d = streak_q + 1'b1;
            end
        end
        if (done) begin
            busRen_d = 1'b0;
            busWen_d = 1'b0;
            if (state_q == I_BUS) begin
                iRdata_d = bus_rdata;
                iReady_d = 1'b1;
            end else begin
                if (!busWen_q) begin
                    dRdata_d = bus_rdata;
                end
                dReady_d = 1'b1;
            end
        end
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            streak_q   <= '0;
            iReady_q   <= 1'b0;
            dReady_q   <= 1'b0;
            iRdata_q   <= '0;
            dRdata_q   <= '0;
            busRen_q   <= 1'b0;
            busWen_q   <= 1'b0;
            busAddr_q  <= '0;
            busWdata_q <= '0;
        end else begin
            streak_q   <= streak_d;
            iReady_q   <= iReady_d;
            dReady_q   <= dReady_d;
            iRdata_q   <= iRdata_d;
            dRdata_q   <= dRdata_d;
            busRen_q   <= busRen_d;
            busWen_q   <= busWen_d;
            busAddr_q  <= busAddr_d;
            busWdata_q <= busWdata_d;
        end
    end

    assign i_ready   = iReady_q;
    assign d_ready   = dReady_q;
    assign i_rdata   = iRdata_q;
    assign d_rdata   = dRdata_q;
    assign bus_ren   = busRen_q;
    assign bus_wen   = busWen_q;
    assign bus_addr  = busAddr_q;
    assign bus_wdata = busWdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Testbench for mem_arbiter: directed scenarios plus random traffic, all checked
// against a transaction-level model of the arbitration rules.
module tb_mem_arbiter;

    localparam int AW   = 32;
    localparam int DW   = 32;
    localparam int MAXS = 4;

    logic          CLK = 1'b0;
    logic          nRST;
    logic          i_ren, d_ren, d_wen, bus_busy;
    logic [AW-1:0] i_addr, d_addr;
    logic [DW-1:0] d_wdata, bus_rdata;
    logic [DW-1:0] i_rdata, d_rdata, bus_wdata;
    logic [AW-1:0] bus_addr;
    logic          i_ready, d_ready, bus_ren, bus_wen;

    int checks = 0;
    int errors = 0;

    always #5 CLK = ~CLK;

    mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MAX_D_STREAK(MAXS)) dut (
        .CLK(CLK), .nRST(nRST),
        .i_ren(i_ren), .i_addr(i_addr), .i_rdata(i_rdata), .i_ready(i_ready),
        .d_ren(d_ren), .d_wen(d_wen), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_rdata(d_rdata), .d_ready(d_ready),
        .bus_ren(bus_ren), .bus_wen(bus_wen), .bus_addr(bus_addr),
        .bus_wdata(bus_wdata), .bus_rdata(bus_rdata), .bus_busy(bus_busy)
    );

    // Reference model: who owns the bus (0 none, 1 fetch, 2 data) and what was latched.
    int          mOwner, mStreak;
    bit          mWrite, mIReady, mDReady;
    logic [31:0] mAddr, mWdata, mIRdata, mDRdata;

    task automatic modelReset();
        mOwner = 0; mStreak = 0; mWrite = 0; mIReady = 0; mDReady = 0;
        mAddr = 0; mWdata = 0; mIRdata = 0; mDRdata = 0;
    endtask

    // One clock: evaluate the arbitration rules on the current inputs, then take the edge.
    task automatic cycle();
        bit iReq, dReq, nIReady, nDReady, nWrite;
        int nOwner, nStreak;
        logic [31:0] nAddr, nWdata, nIRdata, nDRdata;
        iReq = i_ren && !mIReady;
        dReq = (d_ren || d_wen) && !mDReady;
        nOwner = mOwner; nStreak = mStreak; nWrite = mWrite;
        nAddr = mAddr; nWdata = mWdata; nIRdata = mIRdata; nDRdata = mDRdata;
        nIReady = 0; nDReady = 0;
        if (mOwner == 0) begin
            if (dReq && (!iReq || mStreak < MAXS)) begin
                nOwner = 2; nWrite = d_wen; nAddr = d_addr; nWdata = d_wdata;
                nStreak = iReq ? ((mStreak + 1 > MAXS) ? MAXS : mStreak + 1) : 0;
            end else if (iReq) begin
                nOwner = 1; nAddr = i_addr; nStreak = 0;
            end
        end else if (!bus_busy) begin
            if (mOwner == 1) begin
                nIRdata = bus_rdata; nIReady = 1;
            end else begin
                if (!mWrite) nDRdata = bus_rdata;
                nDReady = 1;
            end
            nOwner = 0;
        end
        @(posedge CLK);
        #1;
        mOwner = nOwner; mStreak = nStreak; mWrite = nWrite; mAddr = nAddr;
        mWdata = nWdata; mIRdata = nIRdata; mDRdata = nDRdata;
        mIReady = nIReady; mDReady = nDReady;
    endtask

    function automatic logic [131:0] dutOut();
        logic strobe;
        strobe = bus_ren | bus_wen;
        return {i_ready, d_ready, i_rdata, d_rdata, bus_ren, bus_wen,
                strobe ? bus_addr : 32'h0, bus_wen ? bus_wdata : 32'h0};
    endfunction

    function automatic logic [131:0] modelOut();
        logic ren, wen;
        ren = (mOwner == 1) || (mOwner == 2 && !mWrite);
        wen = (mOwner == 2) && mWrite;
        return {mIReady, mDReady, mIRdata, mDRdata, ren, wen,
                (ren | wen) ? mAddr : 32'h0, wen ? mWdata : 32'h0};
    endfunction

    task automatic test_reset();
        nRST = 1'b0;
        i_ren = 0; d_ren = 0; d_wen = 0; bus_busy = 0;
        i_addr = 0; d_addr = 0; d_wdata = 0; bus_rdata = 0;
        modelReset();
        #12;
        checks++;
        if ({i_ready, d_ready, i_rdata, d_rdata, bus_ren, bus_wen, bus_addr, bus_wdata} !== 132'h0) begin
            errors++;
            $display("[TB] FAIL reset_state: got %h expected 0",
                     {i_ready, d_ready, i_rdata, d_rdata, bus_ren, bus_wen, bus_addr, bus_wdata});
        end
        @(negedge CLK);
        nRST = 1'b1;
        @(posedge CLK);
        #1;
    endtask

    task automatic test_single_fetch();
        i_ren = 1; i_addr = 32'h100; bus_busy = 0; bus_rdata = 32'hDEADBEEF;
        cycle();
        checks++;
        if ({bus_ren, bus_wen, bus_addr} !== {1'b1, 1'b0, 32'h100}) begin
            errors++;
            $display("[TB] FAIL fetch_strobe: got %b%b %h expected 10 00000100", bus_ren, bus_wen, bus_addr);
        end
        cycle();
        checks++;
        if ({i_ready, d_ready, bus_ren, i_rdata} !== {3'b100, 32'hDEADBEEF}) begin
            errors++;
            $display("[TB] FAIL fetch_ready: got %b%b%b %h expected 100 deadbeef", i_ready, d_ready, bus_ren, i_rdata);
        end
        i_ren = 0;
        for (int k = 0; k < 2; k++) begin
            cycle();
            checks++;
            if (dutOut() !== modelOut()) begin
                errors++;
                $display("[TB] FAIL fetch_model: got %h expected %h", dutOut(), modelOut());
            end
        end
    endtask

    task automatic test_data_write();
        int wenCycles = 0;
        d_wen = 1; d_addr = 32'h2000; d_wdata = 32'h12345678;
        bus_busy = 1; bus_rdata = 32'hCAFEF00D;
        cycle();
        for (int k = 0; k < 4; k++) begin
            if (bus_wen) wenCycles++;
            checks++;
            if ({bus_wen, bus_ren, bus_addr, bus_wdata} !== {2'b10, 32'h2000, 32'h12345678}) begin
                errors++;
                $display("[TB] FAIL write_stable: got %b%b %h %h expected 10 00002000 12345678",
                         bus_wen, bus_ren, bus_addr, bus_wdata);
            end
            d_addr = $urandom; d_wdata = $urandom;
            if (k == 3) bus_busy = 0;
            cycle();
        end
        checks++;
        if ({d_ready, bus_wen, d_rdata} !== {2'b10, 32'h0}) begin
            errors++;
            $display("[TB] FAIL write_done: got %b%b %h expected 10 00000000", d_ready, bus_wen, d_rdata);
        end
        checks++;
        if (wenCycles !== 4) begin
            errors++;
            $display("[TB] FAIL write_len: got %0d expected 4", wenCycles);
        end
        d_wen = 0;
        cycle();
        checks++;
        if (dutOut() !== modelOut()) begin
            errors++;
            $display("[TB] FAIL write_model: got %h expected %h", dutOut(), modelOut());
        end
    endtask

    task automatic test_simultaneous();
        int iCnt = 0, dCnt = 0;
        logic prevStrobe = 0;
        logic [31:0] order[$];
        i_addr = 32'h111; d_addr = 32'h222; i_ren = 1; d_ren = 1; bus_busy = 0;
        for (int k = 0; k < 8; k++) begin
            cycle();
            checks++;
            if (dutOut() !== modelOut()) begin
                errors++;
                $display("[TB] FAIL simul_model: got %h expected %h", dutOut(), modelOut());
            end
            if ((bus_ren | bus_wen) && !prevStrobe) order.push_back(bus_addr);
            prevStrobe = bus_ren | bus_wen;
            if (i_ready) begin iCnt++; i_ren = 0; end
            if (d_ready) begin dCnt++; d_ren = 0; end
        end
        checks++;
        if (order.size() != 2 || order[0] !== 32'h222 || order[1] !== 32'h111 || iCnt != 1 || dCnt != 1) begin
            errors++;
            $display("[TB] FAIL simul_order: got grants=%0d i_ready=%0d d_ready=%0d expected D then I, 1 and 1",
                     order.size(), iCnt, dCnt);
        end
    endtask

    task automatic test_streak();
        logic prevStrobe = 0;
        int order[$];
        int expOrder[6] = '{1, 1, 1, 1, 0, 1};
        i_addr = 32'hA000; d_addr = 32'hB000; i_ren = 1; d_ren = 1; d_wen = 0; bus_busy = 0;
        for (int k = 0; k < 40; k++) begin
            cycle();
            checks++;
            if (dutOut() !== modelOut()) begin
                errors++;
                $display("[TB] FAIL streak_model: got %h expected %h", dutOut(), modelOut());
            end
            if ((bus_ren | bus_wen) && !prevStrobe) order.push_back(bus_addr == 32'hB000 ? 1 : 0);
            prevStrobe = bus_ren | bus_wen;
            i_ren = !d_ready;
        end
        for (int k = 0; k < 6; k++) begin
            checks++;
            if (order.size() <= k || order[k] != expOrder[k]) begin
                errors++;
                $display("[TB] FAIL streak_order[%0d]: got %0d expected %0d (1=D 0=I)",
                         k, (order.size() > k) ? order[k] : -1, expOrder[k]);
            end
        end
        i_ren = 0; d_ren = 0;
        for (int k = 0; k < 3; k++) cycle();
    endtask

    task automatic test_reset_mid();
        int iCnt = 0, dCnt = 0;
        d_ren = 1; d_wen = 0; d_addr = 32'h300; bus_busy = 1;
        cycle();
        cycle();
        checks++;
        if ({bus_ren, bus_wen, bus_addr} !== {2'b10, 32'h300}) begin
            errors++;
            $display("[TB] FAIL abort_pre: got %b%b %h expected 10 00000300", bus_ren, bus_wen, bus_addr);
        end
        d_ren = 0; i_ren = 1; i_addr = 32'h400;
        #2 nRST = 1'b0;
        #1;
        checks++;
        if ({bus_ren, bus_wen, bus_addr, d_ready} !== {2'b00, 32'h0, 1'b0}) begin
            errors++;
            $display("[TB] FAIL abort_async: got %b%b %h %b expected 00 00000000 0", bus_ren, bus_wen, bus_addr, d_ready);
        end
        modelReset();
        @(negedge CLK);
        nRST = 1'b1;
        bus_busy = 0; bus_rdata = 32'h0BADF00D;
        for (int k = 0; k < 5; k++) begin
            cycle();
            checks++;
            if (dutOut() !== modelOut()) begin
                errors++;
                $display("[TB] FAIL abort_model: got %h expected %h", dutOut(), modelOut());
            end
            if (i_ready) begin iCnt++; i_ren = 0; end
            if (d_ready) dCnt++;
        end
        checks++;
        if (iCnt != 1 || dCnt != 0) begin
            errors++;
            $display("[TB] FAIL abort_after: got i_ready=%0d d_ready=%0d expected 1 and 0", iCnt, dCnt);
        end
    endtask

    task automatic test_rw_both();
        d_ren = 1; d_wen = 1; d_addr = 32'h40; d_wdata = 32'h55AA55AA; bus_busy = 0;
        cycle();
        checks++;
        if ({bus_wen, bus_ren, bus_addr} !== {2'b10, 32'h40}) begin
            errors++;
            $display("[TB] FAIL rw_both: got wen=%b ren=%b %h expected 1 0 00000040", bus_wen, bus_ren, bus_addr);
        end
        d_ren = 0; d_wen = 0;
        for (int k = 0; k < 2; k++) begin
            cycle();
            checks++;
            if (dutOut() !== modelOut()) begin
                errors++;
                $display("[TB] FAIL rw_model: got %h expected %h", dutOut(), modelOut());
            end
        end
    endtask

    task automatic test_random();
        for (int k = 0; k < 500; k++) begin
            i_ren     = ($urandom % 3) != 0;
            d_ren     = ($urandom % 2) != 0;
            d_wen     = ($urandom % 3) == 0;
            i_addr    = $urandom;
            d_addr    = $urandom;
            d_wdata   = $urandom;
            bus_rdata = $urandom;
            bus_busy  = ($urandom % 3) == 0;
            cycle();
            checks++;
            if (dutOut() !== modelOut()) begin
                errors++;
                $display("[TB] FAIL random[%0d]: got %h expected %h", k, dutOut(), modelOut());
            end
        end
    endtask

    initial begin
        test_reset();
        test_single_fetch();
        test_data_write();
        test_simultaneous();
        test_streak();
        test_reset_mid();
        test_rw_both();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
